// File: rtl/wb_ram_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : wb_ram_arb_pkg
//  Description : Shared types, encodings and defaults for the two-master
//                Wishbone RAM arbiter (state enum, master encoding, grant
//                selection helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_ram_arb_pkg;

    // Arbiter FSM states: bus idle, or owned by master 0 / master 1.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // Identity of the most recently granted master.
    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_t;

    localparam int unsigned TIMEOUT_DEFAULT = 255;
    localparam int unsigned WAIT_W          = 16;

    // Grant decision from an idle bus: a lone requester wins, a tie goes to
    // the master that was not granted most recently.
    function automatic state_t pick_grant(input logic    req0,
                                          input logic    req1,
                                          input master_t last);
        state_t g;
        g = IDLE;
        if (req0 && req1) begin
            g = (last == M0) ? GNT1 : GNT0;
        end else if (req0) begin
            g = GNT0;
        end else if (req1) begin
            g = GNT1;
        end
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_arb_timeout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : wb_arb_timeout
//  Description : 16-bit wait counter for a granted strobe. Counts while
//                enable is high, clears (with priority) on clear, and flags
//                expired while the count equals TIMEOUT.
//  Ports       : clk     - clock
//                rst_n   - asynchronous active-low reset
//                enable  - strobe outstanding without ack this cycle
//                clear   - ack seen or grant changing
//                expired - count has reached TIMEOUT
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arb_timeout
    import wb_ram_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT);

    logic [WAIT_W-1:0] count;

    // The owner is forced off the bus in the cycle the limit is reached,
    // which also clears the counter, so it never runs past LIMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/wb_ram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : wb_ram_arbiter
//  Description : Round-robin arbiter sharing one single-cycle-ack Wishbone
//                RAM between an instruction-fetch master (m0) and a
//                load/store master (m1). The owner keeps the bus while it
//                holds cyc; a stalled strobe is aborted with err after
//                TIMEOUT wait cycles.
//  Ports       : wb_clk_i, wb_rst_n_i        - clock, async active-low reset
//                m0_*_i / m0_*_o             - master 0 request / response
//                m1_*_i / m1_*_o             - master 1 request / response
//                s_*_o / s_dat_i, s_ack_i    - shared RAM request / response
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_ram_arbiter
    import wb_ram_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    // master 0
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    // master 1
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    // shared RAM
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i
);

    state_t  state, state_next;
    master_t last, last_next;

    logic req0, req1;
    logic own_stb;
    logic expired;
    logic timeout_hit;
    logic wait_en;
    logic wait_clr;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    // Strobe of the current owner before any timeout masking.
    assign own_stb = ((state == GNT0) & m0_stb_i) | ((state == GNT1) & m1_stb_i);

    // An ack in the expiry cycle wins, so the abort requires ack low.
    assign timeout_hit = own_stb & ~s_ack_i & expired;
    assign wait_en     = own_stb & ~s_ack_i;
    assign wait_clr    = s_ack_i | (state_next != state);

    // Read data is broadcast; only the ack is steered.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= IDLE;
            last  <= M1;
        end else begin
            state <= state_next;
            last  <= last_next;
        end
    end

    always_comb begin
        state_next = state;
        last_next  = last;
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = 1'b0;
        s_sel_o    = 4'b0000;
        s_adr_o    = 32'h0;
        s_dat_o    = 32'h0;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;

        case (state)
            IDLE: begin
                state_next = pick_grant(req0, req1, last);
            end
            GNT0: begin
                s_cyc_o  = m0_cyc_i & ~timeout_hit;
                s_stb_o  = m0_stb_i & ~timeout_hit;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = timeout_hit;
                if (timeout_hit) begin
                    state_next = IDLE;
                end else if (!m0_cyc_i) begin
                    // Owner released the lock: re-arbitrate in this same
                    // cycle so a waiting master is handed the bus directly.
                    state_next = pick_grant(req0, req1, last);
                end
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i & ~timeout_hit;
                s_stb_o  = m1_stb_i & ~timeout_hit;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = timeout_hit;
                if (timeout_hit) begin
                    state_next = IDLE;
                end else if (!m1_cyc_i) begin
                    state_next = pick_grant(req0, req1, last);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // last tracks every new grant; on a timeout it already names the
        // aborted owner, which hands the next tie to the other master.
        if (state_next == GNT0) begin
            last_next = M0;
        end else if (state_next == GNT1) begin
            last_next = M1;
        end
    end

    wb_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_n_i),
        .enable  (wait_en),
        .clear   (wait_clr),
        .expired (expired)
    );

endmodule
`default_nettype wire

// File: tb/tb_wb_ram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_wb_ram_arbiter
//  Description : Directed self-checking bench for wb_ram_arbiter with a
//                behavioural RAM that acks one cycle after strobe and
//                writes in its ack cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_ram_arbiter;
    import wb_ram_arb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we;
    logic [3:0]  m0_sel;
    logic [31:0] m0_adr, m0_wdat, m0_rdat;
    logic        m0_ack, m0_err;
    logic        m1_cyc, m1_stb, m1_we;
    logic [3:0]  m1_sel;
    logic [31:0] m1_adr, m1_wdat, m1_rdat;
    logic        m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_wdat, s_rdat;
    logic        s_ack;

    logic [31:0] mem [0:63];
    logic        ack_r;
    logic        ack_en;
    logic        force_ack;
    logic        ram_init;

    int n_assert = 0;
    int n_fail   = 0;

    wb_ram_arbiter #(.TIMEOUT(8)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .m0_cyc_i   (m0_cyc),
        .m0_stb_i   (m0_stb),
        .m0_we_i    (m0_we),
        .m0_sel_i   (m0_sel),
        .m0_adr_i   (m0_adr),
        .m0_dat_i   (m0_wdat),
        .m0_dat_o   (m0_rdat),
        .m0_ack_o   (m0_ack),
        .m0_err_o   (m0_err),
        .m1_cyc_i   (m1_cyc),
        .m1_stb_i   (m1_stb),
        .m1_we_i    (m1_we),
        .m1_sel_i   (m1_sel),
        .m1_adr_i   (m1_adr),
        .m1_dat_i   (m1_wdat),
        .m1_dat_o   (m1_rdat),
        .m1_ack_o   (m1_ack),
        .m1_err_o   (m1_err),
        .s_cyc_o    (s_cyc),
        .s_stb_o    (s_stb),
        .s_we_o     (s_we),
        .s_sel_o    (s_sel),
        .s_adr_o    (s_adr),
        .s_dat_o    (s_wdat),
        .s_dat_i    (s_rdat),
        .s_ack_i    (s_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: word i initialised to 0xA000_0000 + i.
    assign s_rdat = mem[s_adr[7:2]];
    assign s_ack  = ack_r | force_ack;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + 32'(i);
            ack_r <= 1'b0;
        end else begin
            ack_r <= s_stb & ~ack_r & ack_en;
            if (s_stb && s_ack && s_we) begin
                for (int b = 0; b < 4; b++)
                    if (s_sel[b]) mem[s_adr[7:2]][8*b +: 8] <= s_wdat[8*b +: 8];
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc_start();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_m0(input logic c, input logic s, input logic w,
                          input logic [3:0] sl, input logic [31:0] a, input logic [31:0] d);
        m0_cyc = c; m0_stb = s; m0_we = w; m0_sel = sl; m0_adr = a; m0_wdat = d;
    endtask

    task automatic set_m1(input logic c, input logic s, input logic w,
                          input logic [3:0] sl, input logic [31:0] a, input logic [31:0] d);
        m1_cyc = c; m1_stb = s; m1_we = w; m1_sel = sl; m1_adr = a; m1_wdat = d;
    endtask

    task automatic do_reset();
        cyc_start();
        rst_n = 1'b0;
        cyc_start();
        cyc_start();
        rst_n = 1'b1;
    endtask

    initial begin
        int order [8];
        int nack;
        int m1acks, m1_at_m0, first_stb, err_cyc, nerr, nack0;
        logic d0, d1, m1_dropped, dropped_at_m0, m0_seen, err_stb;
        logic [31:0] m0_data_seen;

        rst_n = 1'b0; ack_en = 1'b1; force_ack = 1'b0; ram_init = 1'b1;
        set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0);

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        mid();
        check("rst_s_cyc",  32'(s_cyc),  32'd0);
        check("rst_s_stb",  32'(s_stb),  32'd0);
        check("rst_m0_ack", 32'(m0_ack), 32'd0);
        check("rst_m1_ack", 32'(m1_ack), 32'd0);
        check("rst_m0_err", 32'(m0_err), 32'd0);
        check("rst_state",  32'(dut.state), 32'(IDLE));
        check("rst_last",   32'(dut.last),  32'(M1));

        // ---------------- m0 single read of 0x10 ----------------
        cyc_start();
        ram_init = 1'b0; rst_n = 1'b1;
        set_m0(1, 1, 0, 4'hF, 32'h10, 32'h0);
        mid();
        check("rd_c0_stb", 32'(s_stb), 32'd0);
        cyc_start(); mid();
        check("rd_c1_stb", 32'(s_stb), 32'd1);
        check("rd_c1_adr", s_adr, 32'h10);
        check("rd_c1_ack", 32'(m0_ack), 32'd0);
        cyc_start(); mid();
        check("rd_c2_ack",    32'(m0_ack), 32'd1);
        check("rd_c2_data",   m0_rdat, 32'hA000_0004);
        check("rd_c2_m1_ack", 32'(m1_ack), 32'd0);
        cyc_start(); set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0); mid();
        cyc_start(); mid();
        check("rd_idle", 32'(dut.state), 32'(IDLE));

        // ---------------- simultaneous request after reset ----------------
        do_reset();
        set_m0(1, 1, 0, 4'hF, 32'h20, 32'h0);
        set_m1(1, 1, 0, 4'hF, 32'h24, 32'h0);
        mid();
        cyc_start(); mid();
        check("tie_c1_state", 32'(dut.state), 32'(GNT0));
        check("tie_c1_adr",   s_adr, 32'h20);
        cyc_start(); mid();
        check("tie_c2_m0_ack", 32'(m0_ack), 32'd1);
        check("tie_c2_m0_dat", m0_rdat, 32'hA000_0008);
        check("tie_c2_m1_ack", 32'(m1_ack), 32'd0);
        cyc_start(); set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0); mid();
        check("hand_c3_state", 32'(dut.state), 32'(GNT0));
        cyc_start(); mid();
        check("hand_c4_state", 32'(dut.state), 32'(GNT1));
        check("hand_c4_adr",   s_adr, 32'h24);
        cyc_start(); mid();
        check("hand_c5_m1_ack", 32'(m1_ack), 32'd1);
        check("hand_c5_m1_dat", m1_rdat, 32'hA000_0009);
        check("hand_c5_m0_ack", 32'(m0_ack), 32'd0);
        cyc_start(); set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0); mid();
        cyc_start(); mid();
        check("hand_idle", 32'(dut.state), 32'(IDLE));

        // ---------------- round-robin, 8 single transfers ----------------
        nack = 0; d0 = 1'b0; d1 = 1'b0;
        for (int c = 0; c < 60 && nack < 8; c++) begin
            cyc_start();
            set_m0(!d0, !d0, 0, 4'hF, 32'h00, 32'h0);
            set_m1(!d1, !d1, 0, 4'hF, 32'h04, 32'h0);
            d0 = 1'b0; d1 = 1'b0;
            mid();
            if (m0_ack && nack < 8) begin order[nack] = 0; nack++; d0 = 1'b1; end
            if (m1_ack && nack < 8) begin order[nack] = 1; nack++; d1 = 1'b1; end
        end
        check("rr_count", 32'(nack), 32'd8);
        for (int i = 0; i < 8; i++) check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 2));
        cyc_start();
        set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0);
        mid();
        cyc_start(); mid();
        check("rr_idle", 32'(dut.state), 32'(IDLE));

        // ---------------- m1 bus lock, 4 write strobes ----------------
        cyc_start(); set_m1(1, 1, 1, 4'hF, 32'h08, 32'h1234_5678); mid();
        cyc_start(); set_m0(1, 1, 0, 4'hF, 32'h0C, 32'h0); mid();
        m1acks = 0; m1_dropped = 1'b0; m0_seen = 1'b0; m1_at_m0 = -1;
        dropped_at_m0 = 1'b0; m0_data_seen = 32'h0;
        for (int c = 0; c < 30; c++) begin
            cyc_start();
            if (m1acks == 4 && !m1_dropped) begin
                set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0);
                m1_dropped = 1'b1;
            end
            mid();
            if (m1_ack) m1acks++;
            if (m0_ack) begin
                m0_seen = 1'b1; m1_at_m0 = m1acks;
                dropped_at_m0 = m1_dropped; m0_data_seen = m0_rdat;
                break;
            end
        end
        check("lock_m0_seen",    32'(m0_seen), 32'd1);
        check("lock_m1_acks",    32'(m1_at_m0), 32'd4);
        check("lock_m1_dropped", 32'(dropped_at_m0), 32'd1);
        check("lock_m0_data",    m0_data_seen, 32'hA000_0003);
        check("lock_mem2",       mem[2], 32'h1234_5678);
        cyc_start(); set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0); mid();
        cyc_start(); mid();
        check("lock_idle", 32'(dut.state), 32'(IDLE));

        // ---------------- timeout with ack held low ----------------
        ack_en = 1'b0;
        cyc_start(); set_m0(1, 1, 0, 4'hF, 32'h00, 32'h0); mid();
        first_stb = -1; err_cyc = -1; nerr = 0; nack0 = 0; err_stb = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            cyc_start();
            if (c == 10) set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
            mid();
            if (s_stb && first_stb < 0) first_stb = c;
            if (m0_err) begin nerr++; err_cyc = c; err_stb = s_stb; end
            if (m0_ack) nack0++;
        end
        check("to_first_stb", 32'(first_stb), 32'd1);
        check("to_err_cycle", 32'(err_cyc), 32'd9);
        check("to_err_count", 32'(nerr), 32'd1);
        check("to_err_stb",   32'(err_stb), 32'd0);
        check("to_no_ack",    32'(nack0), 32'd0);
        check("to_idle",      32'(dut.state), 32'(IDLE));
        check("to_last",      32'(dut.last), 32'(M0));

        // After an m0 timeout the next tie goes to m1.
        ack_en = 1'b1;
        cyc_start();
        set_m0(1, 1, 0, 4'hF, 32'h00, 32'h0);
        set_m1(1, 1, 0, 4'hF, 32'h04, 32'h0);
        mid();
        cyc_start(); mid();
        check("to_tie_state", 32'(dut.state), 32'(GNT1));
        cyc_start(); mid();
        check("to_tie_m1_ack", 32'(m1_ack), 32'd1);
        cyc_start();
        set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0);
        mid();
        cyc_start(); mid();

        // ---------------- ack in the expiry cycle wins ----------------
        ack_en = 1'b0;
        cyc_start(); set_m0(1, 1, 0, 4'hF, 32'h00, 32'h0); mid();
        nerr = 0;
        for (int c = 1; c <= 8; c++) begin
            cyc_start(); mid();
            if (m0_err) nerr++;
        end
        cyc_start(); force_ack = 1'b1; mid();
        check("race_ack", 32'(m0_ack), 32'd1);
        check("race_err", 32'(m0_err), 32'd0);
        check("race_stb", 32'(s_stb), 32'd1);
        cyc_start(); force_ack = 1'b0; set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0); mid();
        if (m0_err) nerr++;
        check("race_err_total", 32'(nerr), 32'd0);
        ack_en = 1'b1;
        cyc_start(); mid();

        // ---------------- reset during pending m1 write ----------------
        cyc_start(); set_m1(1, 1, 1, 4'b0011, 32'h14, 32'hDEAD_BEEF); mid();
        cyc_start(); mid();
        check("rw_pending_stb", 32'(s_stb), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rw_rst_cyc",    32'(s_cyc),  32'd0);
        check("rw_rst_stb",    32'(s_stb),  32'd0);
        check("rw_rst_m1_ack", 32'(m1_ack), 32'd0);
        check("rw_rst_m1_err", 32'(m1_err), 32'd0);
        cyc_start(); mid();
        check("rw_hold_m1_ack", 32'(m1_ack), 32'd0);
        cyc_start();
        set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0);
        rst_n = 1'b1;
        mid();
        check("rw_rel_m1_ack", 32'(m1_ack), 32'd0);
        cyc_start(); mid();
        check("rw_mem5", mem[5], 32'hA000_0005);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
